// File: rtl/player_anim_fsm.sv
// player_anim_fsm: classifies per-frame player motion into an animation state and steps its frame index.
// Optional LAND state is built when LAND_STATE_EN is defined.
module player_anim_fsm #(
  parameter int WALK_MAX_DX    = 3,
  parameter int ANIM_DIV       = 6,
  parameter int AIR_EXIT_TICKS = 3,
  parameter int LAND_TICKS     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_rate,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic       facing_right,
  input  logic       button_down,
  output logic [2:0] anim_state,
  output logic [1:0] anim_frame,
  output logic       sprite_flip,
  output logic       frame_tick
);
  localparam int DW = ANIM_DIV > 1 ? $clog2(ANIM_DIV) : 1;
  localparam int ZW = $clog2(AIR_EXIT_TICKS + 1);
  localparam logic [DW-1:0] DMAX = DW'(ANIM_DIV - 1);
  localparam logic [ZW-1:0] ZMAX = ZW'(AIR_EXIT_TICKS);
  localparam logic [9:0] WMAX = 10'(WALK_MAX_DX);
`ifdef LAND_STATE_EN
  localparam int LW = LAND_TICKS > 1 ? $clog2(LAND_TICKS) : 1;
  localparam logic [LW-1:0] LMAX = LW'(LAND_TICKS - 1);
`endif
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WALK   = 3'd1,
    RUN    = 3'd2,
    JUMP   = 3'd3,
    FALL   = 3'd4,
    CROUCH = 3'd5
`ifdef LAND_STATE_EN
    , LAND = 3'd6
`endif
  } state_t;
  state_t state, state_n;
  logic [2:0] sync;
  logic [1:0] frame, frame_n;
  logic [DW-1:0] div, div_n;
  logic [ZW-1:0] zero_cnt, zc_n;
  logic [9:0] prev_x, prev_y, px_n, py_n, adx;
  logic primed, primed_n, flip, flip_n, tick, dy_neg, dy_pos;
  state_t gnd;
`ifdef LAND_STATE_EN
  logic [LW-1:0] land_cnt, land_n;
`endif
  function automatic logic [1:0] last_frame(input state_t s);
    return s == IDLE ? 2'd1 : (s == WALK || s == RUN) ? 2'd3 : 2'd0;
  endfunction
  assign tick = sync[1] & ~sync[2];
  assign adx = x_pos >= prev_x ? x_pos - prev_x : prev_x - x_pos;
  assign dy_neg = y_pos < prev_y;
  assign dy_pos = y_pos > prev_y;
  assign gnd = adx > WMAX ? RUN : adx != 10'd0 ? WALK : button_down ? CROUCH : IDLE;
  assign anim_state = state;
  assign anim_frame = frame;
  assign sprite_flip = flip;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync       <= '0;
      state      <= IDLE;
      frame      <= '0;
      div        <= '0;
      zero_cnt   <= '0;
      prev_x     <= '0;
      prev_y     <= '0;
      primed     <= 1'b0;
      flip       <= 1'b1;
      frame_tick <= 1'b0;
`ifdef LAND_STATE_EN
      land_cnt   <= '0;
`endif
    end else begin
      sync       <= {sync[1:0], frame_rate};
      state      <= state_n;
      frame      <= frame_n;
      div        <= div_n;
      zero_cnt   <= zc_n;
      prev_x     <= px_n;
      prev_y     <= py_n;
      primed     <= primed_n;
      flip       <= flip_n;
      frame_tick <= tick;
`ifdef LAND_STATE_EN
      land_cnt   <= land_n;
`endif
    end
  end
  // First tick after reset only captures position so no stale delta is classified.
  always_comb begin
    state_n  = state;
    frame_n  = frame;
    div_n    = div;
    zc_n     = zero_cnt;
    px_n     = prev_x;
    py_n     = prev_y;
    primed_n = primed;
    flip_n   = flip;
`ifdef LAND_STATE_EN
    land_n   = land_cnt;
`endif
    if (tick && !primed) begin
      primed_n = 1'b1;
      px_n     = x_pos;
      py_n     = y_pos;
    end else if (tick) begin
      px_n   = x_pos;
      py_n   = y_pos;
      flip_n = facing_right;
      if (dy_neg) begin
        state_n = JUMP;
        zc_n    = '0;
      end else if (dy_pos) begin
        state_n = FALL;
        zc_n    = '0;
      end else if (state == JUMP || state == FALL) begin
        zc_n = zero_cnt + 1'b1;
        if (zc_n == ZMAX) begin
          zc_n    = '0;
`ifdef LAND_STATE_EN
          state_n = LAND;
          land_n  = LMAX;
`else
          state_n = gnd;
`endif
        end
`ifdef LAND_STATE_EN
      end else if (state == LAND) begin
        if (land_cnt == '0) state_n = gnd;
        else land_n = land_cnt - 1'b1;
`endif
      end else begin
        state_n = gnd;
      end
      if (state_n != state) begin
        frame_n = '0;
        div_n   = '0;
      end else if (div == DMAX) begin
        div_n   = '0;
        frame_n = frame == last_frame(state) ? 2'd0 : frame + 2'd1;
      end else begin
        div_n = div + 1'b1;
      end
    end
  end
endmodule
